pwm_ramp_sequencer: RTL and testbench
=====================================

Name: pwm_ramp_sequencer

Overview:
- Wishbone master that sequences one pwm_timer slave through a duty-cycle ramp.
- On start it programs divisor, period, initial DC and ctrl (PWM mode), then steps DC from a start value to an end value, holding each value for a set number of clocks.
- When the ramp completes, or on abort, it disables the timer and pulses done.
- Sits between the system controller and the pwm_timer Wishbone port.

Parameters:
- ACK_TIMEOUT, 15, max i_clk cycles stb may wait for ack before error (>=1)
- CTRL_RUN, 8'h1E, ctrl value written to start PWM (mode_sel, counter_en, continuous, pwm_out_en set)
- CTRL_STOP, 8'h00, ctrl value written to stop the timer

Ports:
- i_clk  in  1  single clock (also the slave's Wishbone clock)
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle start request; honoured only in IDLE
- i_abort  in  1  one-cycle abort request; honoured while busy
- i_divisor  in  16  divisor value, latched on start
- i_period  in  16  period value, latched on start
- i_dc_start  in  16  first duty-cycle value, latched on start
- i_dc_end  in  16  final duty-cycle value, latched on start
- i_dc_step  in  16  step magnitude, latched on start; 0 means jump straight to end
- i_hold  in  16  clocks per DC value, latched on start; 0 is treated as 1
- o_wb_cyc  out  1  Wishbone cycle
- o_wb_stb  out  1  Wishbone strobe
- o_wb_we  out  1  write enable (always 1 when stb is high)
- o_wb_adr  out  4  0=ctrl, 1=divisor, 2=period, 3=dc
- o_wb_data  out  16  write data (ctrl is zero-extended to 16 bits)
- i_wb_ack  in  1  slave acknowledge
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse at sequence end
- o_status  out  2  valid with o_done: 0=completed, 1=aborted, 2=ack timeout
- o_cur_dc  out  16  DC value most recently acknowledged by the slave

Behaviour:
- Reset (synchronous, i_rst high at posedge):
  - All outputs 0, state IDLE, internal counters 0.
  - Reset has priority over everything, including mid-transaction: cyc and stb drop the next cycle with no stop write.
- Bus write rules:
  - cyc, stb and we are asserted together with adr and data, held stable until i_wb_ack is sampled high.
  - cyc and stb are deasserted in the following cycle, giving at least one idle cycle between writes.
  - With a slave that acks one cycle after stb, each write costs 2 cycles.
- Timeout:
  - A counter runs while stb is high. If ack is not sampled within ACK_TIMEOUT cycles, drop cyc and stb, then go to DONE with status 2.
  - No stop write is issued after a timeout.
- States:
  - IDLE: on i_start, latch inputs, set cur = dc_start, go to WR_DIV.
  - WR_DIV → WR_PER → WR_DC → WR_CTRL: writes divisor, period, dc=cur, ctrl=CTRL_RUN.
  - WR_CTRL → HOLD.
  - HOLD: count max(i_hold,1) cycles. At expiry: if cur == dc_end go to WR_STOP, else go to STEP.
  - STEP:
    - Direction is up if dc_end >= dc_start, else down.
    - Arithmetic is done in 17 bits. Next = cur ± step, clamped to dc_end if it would pass dc_end or wrap past 0/FFFF. Step 0 gives next = dc_end.
    - Go to WR_STEP.
  - WR_STEP: writes dc=next; on ack, cur = next, go to HOLD.
  - WR_STOP: writes ctrl=CTRL_STOP, then go to DONE.
  - DONE: pulse o_done for one cycle with o_status, then go to IDLE.
- o_cur_dc updates only on ack of a dc write.
- Abort:
  - Abort is registered as a pending flag.
  - If a write is in progress, it completes or times out first. Timeout takes precedence, giving status 2.
  - Otherwise go to WR_STOP, and DONE reports status 1.
  - Abort in IDLE, WR_STOP or DONE is ignored.
  - Abort and start in the same cycle in IDLE: start wins, abort is ignored.
- i_start while busy is ignored.
- dc_start == dc_end: a single hold, then stop.
- Inputs changing after start have no effect.

Test Plan:
- Slave acks 1 cycle after stb; start with div=1, per=1000, dc 100→400, step 100, hold 10 → writes (1,1),(2,1000),(3,100),(0,0x1E), then dc writes 200, 300, 400 spaced 10 hold cycles plus write cost, then (0,0x00); done with status 0; o_cur_dc=400.
- Downward ramp dc 500→0, step 200 → dc writes 500, 300, 100, 0 (last clamped, no wrap); status 0.
- Step 0, dc 50→900, hold 0 → dc writes 50 then 900, each held 1 cycle; stop write; status 0.
- Abort asserted during the second hold → current hold ends immediately; next write is (0,0x00); status 1; no further dc writes.
- Slave never acks the period write, ACK_TIMEOUT=15 → stb high exactly 15 cycles, then cyc low; done with status 2; no stop write.
- i_rst asserted while stb is high mid-write → cyc, stb, busy and done are 0 the next cycle; a subsequent start runs a full sequence normally.

Source files
------------

// File: rtl/pwm_ramp_sequencer.sv
// Wishbone master that programs a pwm_timer and steps its duty cycle from a start
// value to an end value, holding each value for a fixed number of clocks.
module pwm_ramp_sequencer #(
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter logic [7:0]  CTRL_RUN    = 8'h1E,
    parameter logic [7:0]  CTRL_STOP   = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [15:0] i_divisor,
    input  logic [15:0] i_period,
    input  logic [15:0] i_dc_start,
    input  logic [15:0] i_dc_end,
    input  logic [15:0] i_dc_step,
    input  logic [15:0] i_hold,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_adr,
    output logic [15:0] o_wb_data,
    input  logic        i_wb_ack,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  o_status,
    output logic [15:0] o_cur_dc
);

    localparam int unsigned TO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_DIV, S_WR_PER, S_WR_DC, S_WR_CTRL,
        S_HOLD, S_STEP, S_WR_STEP, S_WR_STOP, S_DONE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_stb;
    logic [TO_W-1:0] r_to_cnt;
    logic [15:0]     r_hold_cnt;
    logic            r_abort_pend;
    logic [1:0]      r_status;
    logic [15:0]     r_cur_dc;

    logic [15:0]     r_div, r_per, r_dc_end, r_step, r_hold_m1, r_cur, r_next;
    logic            r_up;

    logic            w_is_wr, w_ack, w_timeout, w_hold_last;
    logic [3:0]      w_adr;
    logic [15:0]     w_data;
    state_t          w_wr_after;

    // Next ramp value, clamped to the end value when the step would overshoot it
    // or run past either end of the 16-bit range.
    function automatic logic [15:0] f_next_dc(
        input logic [15:0] cur,
        input logic [15:0] dc_end,
        input logic [15:0] step,
        input logic        up
    );
        logic signed [17:0] cand;
        logic [15:0]        res;
        cand = up ? ($signed({2'b00, cur}) + $signed({2'b00, step}))
                  : ($signed({2'b00, cur}) - $signed({2'b00, step}));
        if (step == 16'd0)
            res = dc_end;
        else if (up && (cand > $signed({2'b00, dc_end})))
            res = dc_end;
        else if (!up && (cand < $signed({2'b00, dc_end})))
            res = dc_end;
        else
            res = cand[15:0];
        return res;
    endfunction

    assign w_is_wr     = (r_state == S_WR_DIV)  || (r_state == S_WR_PER)  ||
                         (r_state == S_WR_DC)   || (r_state == S_WR_CTRL) ||
                         (r_state == S_WR_STEP) || (r_state == S_WR_STOP);
    assign w_ack       = r_stb && i_wb_ack;
    assign w_timeout   = r_stb && !i_wb_ack && (r_to_cnt == TO_LAST);
    assign w_hold_last = (r_hold_cnt == r_hold_m1);

    always_comb begin
        w_wr_after = S_HOLD;
        case (r_state)
            S_WR_DIV: w_wr_after = S_WR_PER;
            S_WR_PER: w_wr_after = S_WR_DC;
            S_WR_DC:  w_wr_after = S_WR_CTRL;
            default:  w_wr_after = S_HOLD;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:
                if (i_start) w_state_nxt = S_WR_DIV;
            S_WR_DIV, S_WR_PER, S_WR_DC, S_WR_CTRL, S_WR_STEP:
                if (w_timeout)
                    w_state_nxt = S_DONE;
                else if (w_ack)
                    w_state_nxt = r_abort_pend ? S_WR_STOP : w_wr_after;
            S_WR_STOP:
                if (w_timeout || w_ack) w_state_nxt = S_DONE;
            S_HOLD:
                if (r_abort_pend)
                    w_state_nxt = S_WR_STOP;
                else if (w_hold_last)
                    w_state_nxt = (r_cur == r_dc_end) ? S_WR_STOP : S_STEP;
            S_STEP:
                w_state_nxt = r_abort_pend ? S_WR_STOP : S_WR_STEP;
            S_DONE:
                w_state_nxt = S_IDLE;
            default:
                w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_adr  = 4'd0;
        w_data = 16'd0;
        case (r_state)
            S_WR_DIV:  begin w_adr = 4'd1; w_data = r_div;              end
            S_WR_PER:  begin w_adr = 4'd2; w_data = r_per;              end
            S_WR_DC:   begin w_adr = 4'd3; w_data = r_cur;              end
            S_WR_CTRL: begin w_adr = 4'd0; w_data = {8'h00, CTRL_RUN};  end
            S_WR_STEP: begin w_adr = 4'd3; w_data = r_next;             end
            S_WR_STOP: begin w_adr = 4'd0; w_data = {8'h00, CTRL_STOP}; end
            default:   begin w_adr = 4'd0; w_data = 16'd0;              end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_stb        <= 1'b0;
            r_to_cnt     <= '0;
            r_hold_cnt   <= '0;
            r_abort_pend <= 1'b0;
            r_status     <= 2'd0;
            r_cur_dc     <= '0;
        end else begin
            r_state <= w_state_nxt;

            // Every write state is entered with stb low, which yields the idle
            // cycle between back-to-back writes.
            if (w_ack || w_timeout)
                r_stb <= 1'b0;
            else if (w_is_wr)
                r_stb <= 1'b1;

            r_to_cnt   <= (r_stb && !i_wb_ack && !w_timeout) ? r_to_cnt + 1'b1 : '0;
            r_hold_cnt <= (r_state == S_HOLD && w_state_nxt == S_HOLD) ? r_hold_cnt + 16'd1 : '0;

            if (r_state == S_IDLE || r_state == S_DONE)
                r_abort_pend <= 1'b0;
            else if (i_abort && r_state != S_WR_STOP)
                r_abort_pend <= 1'b1;

            if (r_state == S_IDLE && i_start)
                r_status <= 2'd0;
            else if (w_timeout)
                r_status <= 2'd2;
            else if (w_state_nxt == S_WR_STOP && r_state != S_WR_STOP)
                r_status <= {1'b0, r_abort_pend};

            if (w_ack && r_state == S_WR_DC)
                r_cur_dc <= r_cur;
            else if (w_ack && r_state == S_WR_STEP)
                r_cur_dc <= r_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_state == S_IDLE && i_start) begin
            r_div     <= i_divisor;
            r_per     <= i_period;
            r_dc_end  <= i_dc_end;
            r_step    <= i_dc_step;
            r_cur     <= i_dc_start;
            r_up      <= (i_dc_end >= i_dc_start);
            r_hold_m1 <= (i_hold == 16'd0) ? 16'd0 : i_hold - 16'd1;
        end
        if (r_state == S_STEP)
            r_next <= f_next_dc(r_cur, r_dc_end, r_step, r_up);
        if (r_state == S_WR_STEP && w_ack)
            r_cur <= r_next;
    end

    assign o_wb_cyc  = r_stb;
    assign o_wb_stb  = r_stb;
    assign o_wb_we   = r_stb;
    assign o_wb_adr  = r_stb ? w_adr : 4'd0;
    assign o_wb_data = r_stb ? w_data : 16'd0;
    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = (r_state == S_DONE);
    assign o_status  = r_status;
    assign o_cur_dc  = r_cur_dc;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Scoreboard bench for pwm_ramp_sequencer: an emulated slave acks writes and a
// monitor compares each acked write and each done pulse against a ramp model.
module tb_pwm_ramp_sequencer;

    logic        clk;
    logic        i_rst, i_start, i_abort, i_wb_ack;
    logic [15:0] i_divisor, i_period, i_dc_start, i_dc_end, i_dc_step, i_hold;
    logic        o_wb_cyc, o_wb_stb, o_wb_we, o_busy, o_done;
    logic [3:0]  o_wb_adr;
    logic [15:0] o_wb_data, o_cur_dc;
    logic [1:0]  o_status;

    pwm_ramp_sequencer #(.ACK_TIMEOUT(15), .CTRL_RUN(8'h1E), .CTRL_STOP(8'h00)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_divisor(i_divisor), .i_period(i_period), .i_dc_start(i_dc_start),
        .i_dc_end(i_dc_end), .i_dc_step(i_dc_step), .i_hold(i_hold),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_adr(o_wb_adr), .o_wb_data(o_wb_data), .i_wb_ack(i_wb_ack),
        .o_busy(o_busy), .o_done(o_done), .o_status(o_status), .o_cur_dc(o_cur_dc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int adr;
        int data;
        bit gap;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_fail = 0;
    int  cyc_n = 0;
    int  last_ack = 0;
    int  n_acks = 0;
    int  stb_run = 0;
    int  stb_cnt = 0;
    int  last_run = 0;
    int  lat = 0;
    int  nack_adr = -1;
    int  exp_hold = 1;
    int  exp_status = 0;
    int  exp_cur = 0;
    bit  exp_done_armed = 0;
    bit  done_seen = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave emulation plus monitor.
    always @(negedge clk) begin
        if (o_wb_stb) begin
            stb_run++;
            if (int'(o_wb_adr) != nack_adr && stb_cnt >= lat) begin
                i_wb_ack = 1'b1;
                n_acks++;
                chk("wr_cyc_we", 32'({o_wb_cyc, o_wb_we}), 32'd3);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: adr %0d data %0h, none expected", o_wb_adr, o_wb_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_adr", 32'(o_wb_adr), 32'(mon_e.adr));
                    chk("wr_data", 32'(o_wb_data), 32'(mon_e.data));
                    if (mon_e.gap) begin
                        n_checks++;
                        if (cyc_n - last_ack < exp_hold + 2) begin
                            n_fail++;
                            $display("FAIL hold_spacing: got %0d cycles, required at least %0d",
                                     cyc_n - last_ack, exp_hold + 2);
                        end
                    end
                end
                last_ack = cyc_n;
            end else begin
                i_wb_ack = 1'b0;
            end
            stb_cnt++;
        end else begin
            if (stb_run != 0) last_run = stb_run;
            stb_run  = 0;
            stb_cnt  = 0;
            i_wb_ack = 1'b0;
        end
        if (o_done) begin
            if (!exp_done_armed) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: status %0d", o_status);
            end else begin
                chk("done_status", 32'(o_status), 32'(exp_status));
                chk("writes_before_done", 32'(exp_q.size()), 32'd0);
                exp_done_armed = 0;
            end
            done_seen = 1;
        end
    end

    task automatic push(input int adr, input int data, input bit gap);
        wr_t w;
        w.adr = adr;
        w.data = data;
        w.gap = gap;
        exp_q.push_back(w);
    endtask

    // Ramp model in plain integer arithmetic: ints never wrap, so clamping is a min/max.
    task automatic model(input int div, input int per, input int s, input int e,
                         input int st, input int hl, input bit ab);
        int cur, nxt, n;
        exp_q.delete();
        push(1, div, 0);
        push(2, per, 0);
        push(3, s, 0);
        push(0, 'h1E, 0);
        cur = s;
        n = 0;
        while (cur != e) begin
            if (st == 0) nxt = e;
            else if (e >= s) nxt = (cur + st > e) ? e : cur + st;
            else nxt = (cur - st < e) ? e : cur - st;
            push(3, nxt, 1);
            cur = nxt;
            n++;
            if (ab && n == 1) break;
        end
        push(0, 0, !ab);
        exp_cur = cur;
        exp_status = ab ? 1 : 0;
        exp_hold = (hl == 0) ? 1 : hl;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done_seen && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (!done_seen) begin
            n_fail++;
            $display("FAIL done_wait: no done within %0d cycles", budget);
        end
    endtask

    task automatic pulse_start(input logic [15:0] div, input logic [15:0] per, input logic [15:0] s,
                               input logic [15:0] e, input logic [15:0] st, input logic [15:0] hl,
                               input bit with_abort);
        @(negedge clk);
        i_divisor = div; i_period = per; i_dc_start = s; i_dc_end = e;
        i_dc_step = st;  i_hold = hl;    i_start = 1'b1;  i_abort = with_abort;
        @(negedge clk);
        i_start = 1'b0;
        i_abort = 1'b0;
        i_divisor = 16'($urandom); i_period = 16'($urandom); i_dc_start = 16'($urandom);
        i_dc_end = 16'($urandom);  i_dc_step = 16'($urandom); i_hold = 16'($urandom);
    endtask

    task automatic run_seq(input logic [15:0] div, input logic [15:0] per, input logic [15:0] s,
                           input logic [15:0] e, input logic [15:0] st, input logic [15:0] hl,
                           input int lat_i, input bit ab, input bit sa);
        int k;
        lat = lat_i;
        model(int'(div), int'(per), int'(s), int'(e), int'(st), int'(hl), ab);
        done_seen = 0;
        exp_done_armed = 1;
        n_acks = 0;
        pulse_start(div, per, s, e, st, hl, sa);
        repeat (2) @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        if (ab) begin
            k = 0;
            while (n_acks < 5 && k < 2000) begin
                @(negedge clk);
                k++;
            end
            repeat (2) @(negedge clk);
            i_abort = 1'b1;
            @(negedge clk);
            i_abort = 1'b0;
        end
        wait_done(5000);
        repeat (3) @(negedge clk);
        chk("busy_after_done", 32'(o_busy), 32'd0);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        chk("cur_dc", 32'(o_cur_dc), 32'(exp_cur));
    endtask

    initial begin
        int s, e, st, diff, k;
        i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        i_divisor = '0; i_period = '0; i_dc_start = '0; i_dc_end = '0; i_dc_step = '0; i_hold = '0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(o_wb_cyc), 32'd0);
        chk("rst_stb", 32'(o_wb_stb), 32'd0);
        chk("rst_we", 32'(o_wb_we), 32'd0);
        chk("rst_adr", 32'(o_wb_adr), 32'd0);
        chk("rst_data", 32'(o_wb_data), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_status", 32'(o_status), 32'd0);
        chk("rst_cur_dc", 32'(o_cur_dc), 32'd0);
        i_rst = 1'b0;
        @(negedge clk);

        // abort while idle must be ignored
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", 32'(o_busy), 32'd0);

        run_seq(16'd1, 16'd1000, 16'd100, 16'd400, 16'd100, 16'd10, 0, 0, 0);
        run_seq(16'd7, 16'd2000, 16'd500, 16'd0, 16'd200, 16'd3, 0, 0, 0);
        run_seq(16'd2, 16'd500, 16'd50, 16'd900, 16'd0, 16'd0, 0, 0, 0);
        run_seq(16'd1, 16'd1000, 16'd100, 16'd400, 16'd100, 16'd10, 0, 1, 0);
        run_seq(16'd5, 16'd5, 16'd300, 16'd300, 16'd7, 16'd2, 1, 0, 0);
        run_seq(16'd3, 16'd300, 16'd1000, 16'd1300, 16'd150, 16'd1, 0, 0, 1);
        run_seq(16'd1, 16'd1, 16'hFF00, 16'hFFFF, 16'h00F0, 16'd1, 0, 0, 0);
        run_seq(16'd1, 16'd1, 16'h0100, 16'h0000, 16'h00C0, 16'd2, 2, 0, 0);

        // slave never acks the period write
        nack_adr = 2;
        lat = 0;
        exp_q.delete();
        push(1, 9, 0);
        exp_status = 2;
        done_seen = 0;
        exp_done_armed = 1;
        pulse_start(16'd9, 16'd99, 16'd10, 16'd20, 16'd5, 16'd1, 0);
        wait_done(200);
        chk("timeout_stb_cycles", 32'(last_run), 32'd15);
        repeat (3) @(negedge clk);
        chk("timeout_busy", 32'(o_busy), 32'd0);
        chk("timeout_pending", 32'(exp_q.size()), 32'd0);
        nack_adr = -1;

        // reset while stb is high
        nack_adr = 1;
        exp_q.delete();
        exp_done_armed = 0;
        pulse_start(16'd4, 16'd44, 16'd1, 16'd2, 16'd1, 16'd1, 0);
        k = 0;
        while (!o_wb_stb && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rst_test_stb_seen", 32'(o_wb_stb), 32'd1);
        repeat (2) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        chk("midrst_cyc", 32'(o_wb_cyc), 32'd0);
        chk("midrst_stb", 32'(o_wb_stb), 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_done", 32'(o_done), 32'd0);
        i_rst = 1'b0;
        nack_adr = -1;
        @(negedge clk);
        run_seq(16'd1, 16'd1000, 16'd100, 16'd400, 16'd100, 16'd4, 0, 0, 0);

        for (int t = 0; t < 8; t++) begin
            s = int'($urandom_range(0, 65535));
            e = (t == 3) ? s : int'($urandom_range(0, 65535));
            diff = (s > e) ? s - e : e - s;
            if ($urandom_range(0, 3) == 0) st = 0;
            else st = diff / int'($urandom_range(1, 6)) + int'($urandom_range(0, 40));
            if (st > 65535) st = 65535;
            run_seq(16'($urandom), 16'($urandom), 16'(s), 16'(e), 16'(st),
                    16'($urandom_range(0, 6)), int'($urandom_range(0, 2)), 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
